// File: rtl/ghash_ctrl.sv
// ghash_ctrl: GHASH sequencer that masks blocks, tracks AAD/ciphertext lengths
// and drives an external GF(2^128) multiplier, one block at a time.
module ghash_ctrl (
   input  logic         iClk,
   input  logic         iRstn,
   input  logic         iStart,
   input  logic [0:127] iHashkey,
   input  logic [0:127] iBlock,
   input  logic [4:0]   iBlock_nbytes,
   input  logic         iBlock_aad,
   input  logic         iBlock_valid,
   output logic         oBlock_ready,
   input  logic         iFinish,
   output logic [0:127] oMul_ctext,
   output logic         oMul_ctext_valid,
   output logic [0:127] oMul_hashkey,
   output logic         oMul_hashkey_valid,
   output logic         oMul_next,
   input  logic [0:127] iMul_result,
   input  logic         iMul_result_valid,
   output logic [0:127] oGhash,
   output logic         oGhash_valid,
   output logic         oOrder_err
);
   localparam logic [2:0] IDLE = 3'd0, ACCEPT = 3'd1, ARM = 3'd2, RUN = 3'd3, DONE = 3'd4;
   logic [2:0]   state;
   logic [0:127] y, masked;
   logic [63:0]  len_a, len_c, bits;
   logic [4:0]   nb;
   logic         fin, seen_c;
   assign oBlock_ready       = state == ACCEPT;
   assign oMul_next          = state == ARM;
   assign oMul_ctext_valid   = state == RUN;
   assign oMul_hashkey_valid = state == RUN;
   assign oGhash_valid       = state == DONE;
   always_comb begin
      nb = (iBlock_nbytes == 5'd0 || iBlock_nbytes > 5'd16) ? 5'd16 : iBlock_nbytes;
      bits = {56'd0, nb, 3'd0};
      masked = '0;
      for (int i = 0; i < 16; i++)
         masked[8*i +: 8] = (5'(i) < nb) ? iBlock[8*i +: 8] : 8'h00;
   end
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state        <= IDLE;
         y            <= '0;
         oMul_hashkey <= '0;
         oMul_ctext   <= '0;
         len_a        <= '0;
         len_c        <= '0;
         fin          <= 1'b0;
         seen_c       <= 1'b0;
         oGhash       <= '0;
         oOrder_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (iStart) begin
               y            <= '0;
               len_a        <= '0;
               len_c        <= '0;
               fin          <= 1'b0;
               seen_c       <= 1'b0;
               oOrder_err   <= 1'b0;
               oMul_hashkey <= iHashkey;
               state        <= ACCEPT;
            end
            ACCEPT: if (iBlock_valid) begin
               oMul_ctext <= y ^ masked;
               if (iBlock_aad) begin
                  len_a <= len_a + bits;
                  if (seen_c) oOrder_err <= 1'b1;
               end else begin
                  len_c  <= len_c + bits;
                  seen_c <= 1'b1;
               end
               state <= ARM;
            end else if (iFinish) begin
               oMul_ctext <= y ^ {len_a, len_c};
               fin        <= 1'b1;
               state      <= ARM;
            end
            ARM: state <= RUN;
            RUN: if (iMul_result_valid) begin
               y <= iMul_result;
               if (fin) oGhash <= iMul_result;
               state <= fin ? DONE : ACCEPT;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: randomized self-checking bench for ghash_ctrl with a
// behavioural GHASH model and a fixed-latency multiplier stand-in.
module tb_ghash_ctrl;
   logic         clk = 0, rst_n = 0, start = 0, aad = 0, bvalid = 0, finish = 0;
   logic [127:0] hkey = '0, blk = '0;
   logic [4:0]   nbytes = '0;
   logic         ready, mcv, mhv, mnext, mresv, gvalid, oerr;
   logic [127:0] mctext, mhkey, mres, ghash;
   int tests = 0, fails = 0, cyc = 0, mcnt = 0, gcnt = 0, dbl_next = 0, no_arm = 0;
   logic prev_next = 0, prev_cv = 0;

   ghash_ctrl dut (
      .iClk(clk), .iRstn(rst_n), .iStart(start), .iHashkey(hkey), .iBlock(blk),
      .iBlock_nbytes(nbytes), .iBlock_aad(aad), .iBlock_valid(bvalid), .oBlock_ready(ready),
      .iFinish(finish), .oMul_ctext(mctext), .oMul_ctext_valid(mcv), .oMul_hashkey(mhkey),
      .oMul_hashkey_valid(mhv), .oMul_next(mnext), .iMul_result(mres), .iMul_result_valid(mresv),
      .oGhash(ghash), .oGhash_valid(gvalid), .oOrder_err(oerr));

   always #5 clk = ~clk;

   function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] v_in);
      logic [127:0] z, v;
      z = '0;
      v = v_in;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
      end
      return z;
   endfunction

   // Multiplier stand-in: answers on the 129th RUN cycle
   assign mresv = mcv && mcnt == 128;
   assign mres  = gf_mul(mctext, mhkey);
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      mcnt      <= mnext ? 0 : (mcv ? mcnt + 1 : mcnt);
      gcnt      <= gcnt + (gvalid ? 1 : 0);
      dbl_next  <= dbl_next + ((mnext && prev_next) ? 1 : 0);
      no_arm    <= no_arm + ((mcv && !prev_cv && !prev_next) ? 1 : 0);
      prev_next <= mnext;
      prev_cv   <= mcv;
   end

   logic [127:0] m_y, m_h;
   logic [63:0]  m_la, m_lc;
   logic         m_err, m_seenc;

   function automatic int eff_n(input logic [4:0] n);
      return (n == 0 || n > 16) ? 16 : int'(n);
   endfunction

   task automatic m_begin(input logic [127:0] h);
      m_y = '0; m_h = h; m_la = '0; m_lc = '0; m_err = 0; m_seenc = 0;
   endtask

   task automatic m_block(input logic [127:0] b, input logic [4:0] n, input logic a, output logic [127:0] x);
      int e;
      e = eff_n(n);
      x = m_y ^ (b & ~({128{1'b1}} >> (8 * e)));
      m_y = gf_mul(x, m_h);
      if (a) begin
         m_la = m_la + 64'(8 * e);
         if (m_seenc) m_err = 1;
      end else begin
         m_lc = m_lc + 64'(8 * e);
         m_seenc = 1;
      end
   endtask

   task automatic m_final(output logic [127:0] x);
      x = m_y ^ {m_la, m_lc};
      m_y = gf_mul(x, m_h);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 500) begin
         tick();
         n++;
      end
      if (!ready) begin
         tests++; fails++;
         $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", ready, n);
      end
   endtask

   task automatic do_start(input logic [127:0] h);
      start = 1; hkey = h;
      tick();
      start = 0;
   endtask

   task automatic accept(input logic [127:0] b, input logic [4:0] n, input logic a, input logic f, output int c0);
      wait_ready();
      blk = b; nbytes = n; aad = a; bvalid = 1; finish = f;
      c0 = cyc;
      tick();
      bvalid = 0; finish = 0;
   endtask

   task automatic send(input logic [127:0] b, input logic [4:0] n, input logic a, output logic [127:0] x, output int lat);
      int c0;
      accept(b, n, a, 0, c0);
      tick();
      x = mctext;
      wait_ready();
      lat = cyc - c0;
   endtask

   task automatic do_finish(output logic [127:0] x, output logic [127:0] g);
      int n = 0;
      wait_ready();
      finish = 1;
      tick();
      finish = 0;
      tick();
      x = mctext;
      while (!gvalid && n < 400) begin
         tick();
         n++;
      end
      if (!gvalid) begin
         tests++; fails++;
         $display("FAIL finish_timeout: oGhash_valid=%0b, required 1", gvalid);
      end
      g = ghash;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) tick();
      tests++; if ({ready, mnext, mcv, mhv, gvalid, oerr} !== 6'b0) begin fails++; $display("FAIL reset_ctrl: got %b, required 000000", {ready, mnext, mcv, mhv, gvalid, oerr}); end
      tests++; if (ghash !== '0 || mhkey !== '0) begin fails++; $display("FAIL reset_data: ghash=%h hkey=%h, required 0", ghash, mhkey); end
      rst_n = 1;
      tick();
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b, required 0", ready); end
   endtask

   task automatic test_empty();
      logic [127:0] h, x, g;
      int g0;
      h = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      do_start(h);
      g0 = gcnt;
      do_finish(x, g);
      tick();
      tests++; if (x !== '0) begin fails++; $display("FAIL empty_x: got %h, required 0", x); end
      tests++; if (g !== '0) begin fails++; $display("FAIL empty_ghash: got %h, required 0", g); end
      tests++; if (gcnt - g0 !== 1) begin fails++; $display("FAIL empty_pulses: got %0d, required 1", gcnt - g0); end
   endtask

   task automatic test_one_block();
      logic [127:0] h, c, x, xe, g;
      int lat;
      h = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      c = 128'h0388dace60b6a392f328c2b971b2fe78;
      do_start(h); m_begin(h);
      m_block(c, 5'd16, 0, xe);
      send(c, 5'd16, 0, x, lat);
      tests++; if (x !== c) begin fails++; $display("FAIL one_x: got %h, required %h", x, c); end
      tests++; if (lat !== 131) begin fails++; $display("FAIL one_latency: got %0d, required 131", lat); end
      do_finish(x, g);
      tests++; if (x !== (128'h5e2ec746917062882c85b0685353deb7 ^ 128'h80)) begin fails++; $display("FAIL one_lenx: got %h, required %h", x, 128'h5e2ec746917062882c85b0685353deb7 ^ 128'h80); end
      m_final(xe);
      tests++; if (g !== m_y) begin fails++; $display("FAIL one_ghash: got %h, required %h", g, m_y); end
      repeat (5) tick();
      tests++; if (ghash !== m_y || gvalid !== 1'b0) begin fails++; $display("FAIL one_hold: got %h/%b, required %h/0", ghash, gvalid, m_y); end
   endtask

   task automatic test_partial();
      logic [127:0] h, x, xe, g;
      int lat;
      h = rand128();
      do_start(h); m_begin(h);
      m_block('1, 5'd5, 1, xe);
      send('1, 5'd5, 1, x, lat);
      tests++; if (x !== 128'hffffffffff0000000000000000000000) begin fails++; $display("FAIL partial_x: got %h, required ffffffffff00..00", x); end
      do_finish(x, g);
      m_final(xe);
      tests++; if (x !== (gf_mul(128'hffffffffff0000000000000000000000, h) ^ {64'd40, 64'd0})) begin fails++; $display("FAIL partial_lenx: got %h, required %h", x, xe); end
      tests++; if (g !== m_y) begin fails++; $display("FAIL partial_ghash: got %h, required %h", g, m_y); end
   endtask

   task automatic test_order_priority();
      logic [127:0] h, b, x, xe, g;
      int lat, c0, g0;
      h = rand128();
      do_start(h); m_begin(h);
      b = rand128();
      m_block(b, 5'd16, 0, xe);
      send(b, 5'd16, 0, x, lat);
      tests++; if (oerr !== 1'b0) begin fails++; $display("FAIL order_early: got %b, required 0", oerr); end
      b = rand128();
      m_block(b, 5'd9, 1, xe);
      g0 = gcnt;
      accept(b, 5'd9, 1, 1, c0);
      tick();
      tests++; if (mctext !== xe) begin fails++; $display("FAIL prio_x: got %h, required %h", mctext, xe); end
      wait_ready();
      tests++; if (cyc - c0 !== 131) begin fails++; $display("FAIL prio_latency: got %0d, required 131", cyc - c0); end
      tests++; if (gcnt !== g0) begin fails++; $display("FAIL prio_finish_dropped: pulses %0d, required 0", gcnt - g0); end
      tests++; if (oerr !== 1'b1) begin fails++; $display("FAIL order_err: got %b, required 1", oerr); end
      do_finish(x, g);
      m_final(xe);
      tests++; if (g !== m_y) begin fails++; $display("FAIL order_ghash: got %h, required %h", g, m_y); end
   endtask

   task automatic test_random();
      logic [127:0] h, b, x, xe, g;
      logic [4:0] n;
      logic a;
      int lat;
      for (int m = 0; m < 5; m++) begin
         h = rand128();
         do_start(h); m_begin(h);
         if (m == 0) do_start(~h);
         for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            b = rand128(); n = 5'($urandom_range(0, 31)); a = 1'($urandom_range(0, 1));
            m_block(b, n, a, xe);
            send(b, n, a, x, lat);
            tests++; if (x !== xe) begin fails++; $display("FAIL rand_x m%0d k%0d: got %h, required %h", m, k, x, xe); end
            tests++; if (mhkey !== h) begin fails++; $display("FAIL rand_hkey m%0d: got %h, required %h", m, mhkey, h); end
         end
         do_finish(x, g);
         m_final(xe);
         tests++; if (x !== xe) begin fails++; $display("FAIL rand_lenx m%0d: got %h, required %h", m, x, xe); end
         tests++; if (g !== m_y) begin fails++; $display("FAIL rand_ghash m%0d: got %h, required %h", m, g, m_y); end
         tests++; if (oerr !== m_err) begin fails++; $display("FAIL rand_order m%0d: got %b, required %b", m, oerr, m_err); end
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] h, b, x, xe, g;
      int c0, g0, lat;
      h = rand128();
      do_start(h);
      accept(rand128(), 5'd16, 0, 0, c0);
      repeat (59) tick();
      tests++; if (mcv !== 1'b1 || cyc - c0 !== 60) begin fails++; $display("FAIL mid_in_run: valid=%b cycle=%0d, required 1/60", mcv, cyc - c0); end
      g0 = gcnt;
      rst_n = 0;
      #1;
      tests++; if ({ready, mnext, mcv, mhv, gvalid, oerr} !== 6'b0) begin fails++; $display("FAIL mid_reset_ctrl: got %b, required 000000", {ready, mnext, mcv, mhv, gvalid, oerr}); end
      tests++; if (ghash !== '0 || mhkey !== '0 || mctext !== '0) begin fails++; $display("FAIL mid_reset_data: ghash=%h hkey=%h x=%h, required 0", ghash, mhkey, mctext); end
      tick(); tick();
      rst_n = 1;
      repeat (3) tick();
      tests++; if (gcnt !== g0 || ready !== 1'b0) begin fails++; $display("FAIL mid_abort: pulses=%0d ready=%b, required 0/0", gcnt - g0, ready); end
      h = rand128(); b = rand128();
      do_start(h); m_begin(h);
      m_block(b, 5'd16, 0, xe);
      send(b, 5'd16, 0, x, lat);
      do_finish(x, g);
      m_final(xe);
      tests++; if (g !== m_y) begin fails++; $display("FAIL mid_rerun_ghash: got %h, required %h", g, m_y); end
   endtask

   task automatic test_monitors();
      tests++; if (dbl_next !== 0) begin fails++; $display("FAIL next_twice: got %0d, required 0", dbl_next); end
      tests++; if (no_arm !== 0) begin fails++; $display("FAIL run_without_arm: got %0d, required 0", no_arm); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_one_block();
      test_partial();
      test_order_priority();
      test_random();
      test_reset_mid();
      test_monitors();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
